// File: rtl/ccip_mmio_csr_responder.sv
// ccip_mmio_csr_responder
//
// MMIO responder for an AFU's CSR space. Decodes host MMIO reads and writes
// from the c0 Rx channel and answers reads on c2 Tx with a fixed 2-cycle
// latency.
//
// Register map (64-bit word index = address[15:1]):
//   0                DFH_VALUE            RO
//   1                AFU_ID[63:0]         RO
//   2                AFU_ID[127:64]       RO
//   3                MMIO read count      RO (0 unless CCIP_MMIO_RD_COUNT_EN)
//   4..4+N_SCRATCH-1 scratch              RW
//   others           read 0, writes ignored
//
// Ports:
//   clk         CCI-P clock
//   reset       synchronous, active-high
//   c0Rx        c0 Rx channel (mmioRdValid/mmioWrValid, MMIO hdr view, data[63:0])
//   c2Tx        MMIO read response (mmioRdValid, hdr.tid, data)
//   scratch     scratch register values, scratch[0] in the LSBs
//   csr_wr_err  one-cycle pulse on an unsupported MMIO access
//
// Build option: define CCIP_MMIO_RD_COUNT_EN to make word 3 return the number
// of MMIO read responses issued so far.

package ccip_if_pkg;
  typedef logic [8:0]  t_ccip_tid;
  typedef logic [15:0] t_ccip_mmioAddr;
  typedef logic [63:0] t_ccip_mmioData;

  localparam logic [1:0] CCIP_MMIO_LEN_4B  = 2'd0;
  localparam logic [1:0] CCIP_MMIO_LEN_8B  = 2'd1;
  localparam logic [1:0] CCIP_MMIO_LEN_64B = 2'd2;

  localparam int CCIP_C0RX_HDR_WIDTH = 28;

  typedef struct packed {
    t_ccip_mmioAddr address;
    logic [1:0]     length;
    logic           rsvd;
    t_ccip_tid      tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    logic [CCIP_C0RX_HDR_WIDTH-1:0] hdr;
    logic [511:0]                   data;
    logic                           rspValid;
    logic                           mmioRdValid;
    logic                           mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_tid tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    t_ccip_mmioData      data;
  } t_if_ccip_c2_Tx;
endpackage

module ccip_mmio_csr_responder
  import ccip_if_pkg::*;
#(
  parameter logic [63:0]  DFH_VALUE = 64'h1000_0000_0000_0000,
  parameter logic [127:0] AFU_ID    = 128'h0,
  parameter int           N_SCRATCH = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  t_if_ccip_c0_Rx          c0Rx,
  output t_if_ccip_c2_Tx          c2Tx,
  output logic [N_SCRATCH*64-1:0] scratch,
  output logic                    csr_wr_err
);

  localparam logic [14:0] IDX_DFH      = 15'd0;
  localparam logic [14:0] IDX_AFU_LO   = 15'd1;
  localparam logic [14:0] IDX_AFU_HI   = 15'd2;
  localparam logic [14:0] IDX_SCR_BASE = 15'd4;

  t_ccip_c0_ReqMmioHdr mmio_hdr;
  logic [14:0] req_idx;
  logic        req_hi;
  logic [1:0]  req_len;
  logic        wr_full, wr_half, wr_bad, rd_ok, rd_bad;

  logic [63:0] scratch_q [N_SCRATCH];
  logic [63:0] rd_sel;

  logic        s1_valid;
  t_ccip_tid   s1_tid;
  logic        s1_dword;
  logic        s1_hi;
  logic [63:0] s1_data;

  logic        rsp_valid_q;
  t_ccip_tid   rsp_tid_q;
  logic [63:0] rsp_data_q;
  logic [63:0] rsp_word;

  logic unused_rx;

  assign mmio_hdr  = t_ccip_c0_ReqMmioHdr'(c0Rx.hdr);
  assign unused_rx = &{1'b0, c0Rx.rspValid, c0Rx.data[511:64], mmio_hdr.rsvd};

  always_comb begin
    req_idx = mmio_hdr.address[15:1];
    req_hi  = mmio_hdr.address[0];
    req_len = mmio_hdr.length;
    wr_full = c0Rx.mmioWrValid && (req_len == CCIP_MMIO_LEN_8B) && !req_hi;
    wr_half = c0Rx.mmioWrValid && (req_len == CCIP_MMIO_LEN_4B);
    wr_bad  = c0Rx.mmioWrValid && !(wr_full || wr_half);
    rd_ok   = c0Rx.mmioRdValid &&
              ((req_len == CCIP_MMIO_LEN_4B) || (req_len == CCIP_MMIO_LEN_8B));
    rd_bad  = c0Rx.mmioRdValid && !rd_ok;
  end

  // The register value is captured in stage 1, in the request cycle, so a
  // read colliding with a write to the same word returns the pre-write value.
  always_comb begin
    rd_sel = '0;
    case (req_idx)
      IDX_DFH:    rd_sel = DFH_VALUE;
      IDX_AFU_LO: rd_sel = AFU_ID[63:0];
      IDX_AFU_HI: rd_sel = AFU_ID[127:64];
      default:    ;
    endcase
    for (int i = 0; i < N_SCRATCH; i++) begin
      if (req_idx == IDX_SCR_BASE + 15'(i)) rd_sel = scratch_q[i];
    end
  end

`ifdef CCIP_MMIO_RD_COUNT_EN
  localparam logic [14:0] IDX_RD_CNT = 15'd3;

  logic [63:0] rd_count;
  logic        s1_is_cnt;

  // Counts responses as they are loaded into c2Tx, so a count read sees every
  // response issued before its own.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count  <= '0;
      s1_is_cnt <= 1'b0;
    end else begin
      if (s1_valid) rd_count <= rd_count + 64'd1;
      if (rd_ok) s1_is_cnt <= (req_idx == IDX_RD_CNT);
    end
  end

  assign rsp_word = s1_is_cnt ? rd_count : s1_data;
`else
  assign rsp_word = s1_data;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_SCRATCH; i++) scratch_q[i] <= '0;
      s1_valid    <= 1'b0;
      s1_tid      <= '0;
      s1_dword    <= 1'b0;
      s1_hi       <= 1'b0;
      s1_data     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_tid_q   <= '0;
      rsp_data_q  <= '0;
      csr_wr_err  <= 1'b0;
    end else begin
      for (int i = 0; i < N_SCRATCH; i++) begin
        if (req_idx == IDX_SCR_BASE + 15'(i)) begin
          if (wr_full)                scratch_q[i]        <= c0Rx.data[63:0];
          else if (wr_half && req_hi) scratch_q[i][63:32] <= c0Rx.data[31:0];
          else if (wr_half)           scratch_q[i][31:0]  <= c0Rx.data[31:0];
        end
      end

      s1_valid <= rd_ok;
      if (rd_ok) begin
        s1_tid   <= mmio_hdr.tid;
        s1_dword <= (req_len == CCIP_MMIO_LEN_4B);
        s1_hi    <= req_hi;
        s1_data  <= rd_sel;
      end

      // Data and tid only move with a response so they stay stable when idle.
      rsp_valid_q <= s1_valid;
      if (s1_valid) begin
        rsp_tid_q  <= s1_tid;
        rsp_data_q <= s1_dword ? {2{s1_hi ? rsp_word[63:32] : rsp_word[31:0]}} : rsp_word;
      end

      csr_wr_err <= wr_bad | rd_bad;
    end
  end

  always_comb begin
    scratch = '0;
    for (int i = 0; i < N_SCRATCH; i++) scratch[i*64 +: 64] = scratch_q[i];
  end

  always_comb begin
    c2Tx             = '0;
    c2Tx.mmioRdValid = rsp_valid_q;
    c2Tx.hdr.tid     = rsp_tid_q;
    c2Tx.data        = rsp_data_q;
  end

endmodule

// File: tb/tb_ccip_mmio_csr_responder.sv
// Testbench for ccip_mmio_csr_responder. Directed stimulus; expected read
// responses are queued with their due cycle when a read is driven and popped
// by a monitor that also tracks csr_wr_err and the scratch outputs each cycle.
// Honours CCIP_MMIO_RD_COUNT_EN for the expected value of word 3.

module tb_ccip_mmio_csr_responder;
  import ccip_if_pkg::*;

  localparam logic [63:0]  DFH = 64'h1000_0000_0000_0000;
  localparam logic [127:0] AFU = 128'hFEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978;
  localparam int           NS  = 4;
  localparam logic [1:0]   L4  = 2'd0;
  localparam logic [1:0]   L8  = 2'd1;
  localparam logic [1:0]   L64 = 2'd2;

  logic              clk = 1'b0;
  logic              reset;
  t_if_ccip_c0_Rx    c0Rx;
  t_if_ccip_c2_Tx    c2Tx;
  logic [NS*64-1:0]  scratch;
  logic              csr_wr_err;

  ccip_mmio_csr_responder #(
    .DFH_VALUE(DFH),
    .AFU_ID   (AFU),
    .N_SCRATCH(NS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .c0Rx      (c0Rx),
    .c2Tx      (c2Tx),
    .scratch   (scratch),
    .csr_wr_err(csr_wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          due;
  } exp_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  bit          err_drive = 1'b0;
  bit          exp_err;
  logic [63:0] m_scr [NS];
  logic [63:0] m_cnt;
  exp_t        sb[$];
  exp_t        e;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [63:0] model_rd(input logic [15:0] addr, input logic [1:0] len);
    int          idx;
    logic [63:0] w;
    idx = int'(addr[15:1]);
    w   = '0;
    if (idx == 0) w = DFH;
    else if (idx == 1) w = AFU[63:0];
    else if (idx == 2) w = AFU[127:64];
`ifdef CCIP_MMIO_RD_COUNT_EN
    else if (idx == 3) w = m_cnt;
`endif
    else if (idx >= 4 && idx < 4 + NS) w = m_scr[idx-4];
    if (len == L4) w = addr[0] ? {2{w[63:32]}} : {2{w[31:0]}};
    return w;
  endfunction

  // Drives one request cycle; the model is updated read-before-write.
  task automatic drive(input bit rd, input bit wr, input logic [15:0] addr,
                       input logic [1:0] len, input logic [8:0] tid, input logic [63:0] data);
    t_ccip_c0_ReqMmioHdr mh;
    int idx;
    exp_t x;
    @(negedge clk);
    mh = '0;
    mh.address = addr;
    mh.length  = len;
    mh.tid     = tid;
    c0Rx = '0;
    c0Rx.hdr = mh;
    c0Rx.data = {{448{1'b1}}, data};
    c0Rx.mmioRdValid = rd;
    c0Rx.mmioWrValid = wr;
    err_drive = (rd && len > L8) || (wr && !(len == L4 || (len == L8 && !addr[0])));
    if (!reset) begin
      if (rd && len <= L8) begin
        x.tid  = tid;
        x.data = model_rd(addr, len);
        x.due  = cyc + 2;
        sb.push_back(x);
        m_cnt = m_cnt + 64'd1;
      end
      idx = int'(addr[15:1]) - 4;
      if (wr && idx >= 0 && idx < NS) begin
        if (len == L8 && !addr[0]) m_scr[idx] = data;
        else if (len == L4 && addr[0]) m_scr[idx][63:32] = data[31:0];
        else if (len == L4) m_scr[idx][31:0] = data[31:0];
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      c0Rx = '0;
      err_drive = 1'b0;
    end
  endtask

  task automatic set_reset(input bit r);
    @(negedge clk);
    reset = r;
    c0Rx = '0;
    err_drive = 1'b0;
    if (r) begin
      sb.delete();
      m_scr = '{default: 64'h0};
      m_cnt = '0;
    end
  endtask

  always @(posedge clk) begin
    exp_err = err_drive && !reset;
    cyc++;
    #1;
    check("csr_wr_err", 64'(csr_wr_err), 64'(exp_err));
    for (int i = 0; i < NS; i++) check($sformatf("scratch%0d", i), scratch[i*64 +: 64], m_scr[i]);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("rsp_valid", 64'(c2Tx.mmioRdValid), 64'd1);
      check("rsp_tid", 64'(c2Tx.hdr.tid), 64'(e.tid));
      check("rsp_data", c2Tx.data, e.data);
    end else begin
      check("rsp_idle", 64'(c2Tx.mmioRdValid), 64'd0);
    end
  end

  initial begin
    reset = 1'b1;
    c0Rx  = '0;
    m_scr = '{default: 64'h0};
    m_cnt = '0;
    idle(2);
    // Requests while in reset are ignored.
    drive(1'b1, 1'b1, 16'h0008, L8, 9'h0AA, 64'h1111_2222_3333_4444);
    idle(1);
    set_reset(1'b0);
    idle(2);

    // DFH read
    drive(1'b1, 1'b0, 16'h0000, L8, 9'h005, 64'h0);
    idle(4);

    // 8B write then read next cycle
    drive(1'b0, 1'b1, 16'h0008, L8, 9'h000, 64'hDEAD_BEEF_0123_4567);
    drive(1'b1, 1'b0, 16'h0008, L8, 9'h1FF, 64'h0);
    idle(3);

    // 4B write to upper half, 4B reads of both halves
    drive(1'b0, 1'b1, 16'h0009, L4, 9'h000, 64'h1357_9BDF_AAAA_5555);
    drive(1'b1, 1'b0, 16'h0008, L4, 9'h010, 64'h0);
    drive(1'b1, 1'b0, 16'h0009, L4, 9'h011, 64'h0);
    idle(3);

    // Back-to-back reads, AFU ID words included
    drive(1'b1, 1'b0, 16'h0000, L8, 9'h001, 64'h0);
    drive(1'b1, 1'b0, 16'h0002, L8, 9'h002, 64'h0);
    drive(1'b1, 1'b0, 16'h0004, L8, 9'h003, 64'h0);
    drive(1'b1, 1'b0, 16'h0008, L8, 9'h004, 64'h0);
    idle(3);

    // Same-cycle read/write of scratch[1], then read next cycle
    drive(1'b1, 1'b1, 16'h000A, L8, 9'h020, 64'h1);
    drive(1'b1, 1'b0, 16'h000A, L8, 9'h021, 64'h0);
    idle(3);

    // Unsupported accesses
    drive(1'b1, 1'b0, 16'h0000, L64, 9'h030, 64'h0);
    idle(2);
    drive(1'b0, 1'b1, 16'h000B, L8, 9'h000, 64'hBAD0_BAD0_BAD0_BAD0);
    idle(1);
    drive(1'b0, 1'b1, 16'h000C, L64, 9'h000, 64'hBAD1_BAD1_BAD1_BAD1);
    idle(2);

    // Unmapped and out-of-range indices
    drive(1'b0, 1'b1, 16'h0020, L8, 9'h000, 64'h5555_6666_7777_8888);
    drive(1'b0, 1'b1, 16'h0010, L8, 9'h000, 64'h9999_AAAA_BBBB_CCCC);
    drive(1'b1, 1'b0, 16'h0020, L8, 9'h031, 64'h0);
    drive(1'b1, 1'b0, 16'h0010, L8, 9'h032, 64'h0);
    drive(1'b0, 1'b1, 16'h000E, L4, 9'h000, 64'hFFFF_FFFF_CAFE_F00D);
    drive(1'b1, 1'b0, 16'h000E, L8, 9'h033, 64'h0);
    drive(1'b1, 1'b0, 16'h000F, L4, 9'h034, 64'h0);
    idle(3);

    // Read in flight at reset is dropped; state clears
    drive(1'b1, 1'b0, 16'h0008, L8, 9'h040, 64'h0);
    set_reset(1'b1);
    idle(2);
    set_reset(1'b0);
    drive(1'b1, 1'b0, 16'h0008, L8, 9'h041, 64'h0);
    idle(3);

    // Read-count word after a fresh reset and 3 responses
    set_reset(1'b1);
    idle(1);
    set_reset(1'b0);
    drive(1'b1, 1'b0, 16'h0000, L8, 9'h050, 64'h0);
    drive(1'b1, 1'b0, 16'h0002, L8, 9'h051, 64'h0);
    drive(1'b1, 1'b0, 16'h0004, L8, 9'h052, 64'h0);
    idle(3);
    drive(1'b1, 1'b0, 16'h0006, L8, 9'h053, 64'h0);
    drive(1'b1, 1'b0, 16'h0006, L4, 9'h054, 64'h0);
    idle(5);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
